// File: rtl/alu_pipe_if.sv
// Handshake and result bundle for alu_pipe: operand side, result side and sticky-overflow control.
// master = producer/consumer environment, slave = the ALU itself.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             set;
  logic             cout;
  logic             busy;
  logic             sticky_ovf;
  logic             clr_sticky;

  modport master (
    output in_valid, a, b, op, out_ready, clr_sticky,
    input  in_ready, out_valid, result, zero, overflow, set, cout, busy, sticky_ovf
  );

  modport slave (
    input  in_valid, a, b, op, out_ready, clr_sticky,
    output in_ready, out_valid, result, zero, overflow, set, cout, busy, sticky_ovf
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU: logic/add/sub/slt/shift ops in one cycle, shift-add multiply over WIDTH cycles.
// Optional sticky overflow flag enabled by defining ALU_STICKY_OVF_EN.
module alu_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  alu_pipe_if.slave bus
);
  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t           state_r;
  logic [WIDTH-1:0] mcand_r, mplier_r, acc_r, result_r;
  logic [SHW-1:0]   cnt_r;
  logic             out_valid_r, busy_r, zero_r, ovf_r, set_r, cout_r;

  logic             accept_s, is_mul_s;
  logic [WIDTH-1:0] b_eff_s, alu_res_s, acc_next_s;
  logic [WIDTH:0]   sum_s;
  logic [SHW-1:0]   shamt_s;
  logic             add_ovf_s, slt_s, alu_ovf_s, alu_set_s, alu_cout_s, alu_zero_s;

  assign bus.in_ready = (state_r == IDLE) && (!out_valid_r || bus.out_ready);
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign is_mul_s     = (bus.op == 4'b1000);

  // single-cycle datapath: shared adder, logic, shifts and flag selection
  always_comb begin
    b_eff_s    = bus.b ^ {WIDTH{bus.op[2]}};
    sum_s      = {1'b0, bus.a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, bus.op[2]};
    add_ovf_s  = (bus.a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
    slt_s      = sum_s[WIDTH-1] ^ add_ovf_s;
    shamt_s    = bus.b[SHW-1:0];
    alu_res_s  = {WIDTH{1'b0}};
    alu_ovf_s  = 1'b0;
    alu_set_s  = 1'b0;
    alu_cout_s = 1'b0;
    alu_zero_s = 1'b0;
    if (bus.op[3] == 1'b0) begin
      case (bus.op[1:0])
        2'b00:   alu_res_s = bus.a & b_eff_s;
        2'b01:   alu_res_s = bus.a | b_eff_s;
        2'b10: begin
          alu_res_s  = sum_s[WIDTH-1:0];
          alu_ovf_s  = add_ovf_s;
          alu_cout_s = sum_s[WIDTH];
        end
        2'b11: begin
          alu_res_s = {{(WIDTH-1){1'b0}}, slt_s};
          alu_set_s = slt_s;
        end
        default: alu_res_s = {WIDTH{1'b0}};
      endcase
      alu_zero_s = (alu_res_s == {WIDTH{1'b0}});
    end else if (bus.op[2] == 1'b0) begin
      case (bus.op[1:0])
        2'b01:   alu_res_s = bus.a << shamt_s;
        2'b10:   alu_res_s = bus.a >> shamt_s;
        2'b11:   alu_res_s = $signed(bus.a) >>> shamt_s;
        default: alu_res_s = {WIDTH{1'b0}};
      endcase
      alu_zero_s = (alu_res_s == {WIDTH{1'b0}});
    end else begin
      // reserved ops report result 0 with every flag cleared
      alu_res_s  = {WIDTH{1'b0}};
      alu_zero_s = 1'b0;
    end
  end

  // one shift-add step of the multiplier
  always_comb begin
    acc_next_s = acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
  end

  // control FSM, multiplier state and the registered result/flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      mcand_r     <= {WIDTH{1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      cnt_r       <= {SHW{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      set_r       <= 1'b0;
      cout_r      <= 1'b0;
    end else begin
      if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (accept_s && is_mul_s) begin
            mcand_r  <= bus.a;
            mplier_r <= bus.b;
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {SHW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= MUL;
          end else if (accept_s) begin
            result_r    <= alu_res_s;
            zero_r      <= alu_zero_s;
            ovf_r       <= alu_ovf_s;
            set_r       <= alu_set_s;
            cout_r      <= alu_cout_s;
            out_valid_r <= 1'b1;
          end
        end
        MUL: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + SHW'(1);
          if (cnt_r == SHW'(WIDTH - 1)) begin
            result_r    <= acc_next_s;
            zero_r      <= (acc_next_s == {WIDTH{1'b0}});
            ovf_r       <= 1'b0;
            set_r       <= 1'b0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.zero      = zero_r;
  assign bus.overflow  = ovf_r;
  assign bus.set       = set_r;
  assign bus.cout      = cout_r;
  assign bus.busy      = busy_r;

`ifdef ALU_STICKY_OVF_EN
  logic sticky_r;

  // sticky overflow: setting on an overflowing load wins over a same-edge clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 1'b0;
    end else if (accept_s && !is_mul_s && alu_ovf_s) begin
      sticky_r <= 1'b1;
    end else if (bus.clr_sticky) begin
      sticky_r <= 1'b0;
    end
  end

  assign bus.sticky_ovf = sticky_r;
`else
  logic unused_clr_sticky_s;
  assign unused_clr_sticky_s = bus.clr_sticky;
  assign bus.sticky_ovf      = 1'b0;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push expectations, monitors pop on each delivered result.
module tb_alu_pipe;
  typedef struct {
    logic [31:0] res;
    logic        z, o, s, c;
    bit          zmask;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t q8[$];

  alu_pipe_if #(.WIDTH(32)) bus();
  alu_pipe_if #(.WIDTH(8))  bus8();

  alu_pipe #(.WIDTH(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_pipe #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // 32-bit result monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got %h, required no result", bus.result);
      end else begin
        e = q.pop_front();
        if (bus.result !== e.res || (!e.zmask && bus.zero !== e.z) || bus.overflow !== e.o ||
            bus.set !== e.s || bus.cout !== e.c) begin
          errors++;
          $display("FAIL %s: got res=%h z=%b o=%b s=%b c=%b, required res=%h z=%b o=%b s=%b c=%b",
                   e.nm, bus.result, bus.zero, bus.overflow, bus.set, bus.cout,
                   e.res, e.z, e.o, e.s, e.c);
        end
      end
    end
  end

  // 8-bit result monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus8.out_valid && bus8.out_ready) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result8: got %h, required no result", bus8.result);
      end else begin
        e = q8.pop_front();
        if ({24'h0, bus8.result} !== e.res || bus8.zero !== e.z || bus8.overflow !== e.o ||
            bus8.set !== e.s || bus8.cout !== e.c) begin
          errors++;
          $display("FAIL %s: got res=%h z=%b, required res=%h z=%b",
                   e.nm, bus8.result, bus8.zero, e.res[7:0], e.z);
        end
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] iop,
                       input logic [31:0] r, input logic z, input logic o, input logic s,
                       input logic c, input bit zmask, input bit push, input string nm);
    int n;
    if (push) q.push_back('{res: r, z: z, o: o, s: s, c: c, zmask: zmask, nm: nm});
    bus.a        = ia;
    bus.b        = ib;
    bus.op       = iop;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got no accept, required accept within 100 cycles", nm);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (push && iop != 4'b1000) chk({nm, "_lat1"}, {31'h0, bus.out_valid}, 32'h1);
  endtask

  initial begin
    bit bad;
    logic [31:0] held;
    bus.in_valid = 1'b0; bus.a = 32'h0; bus.b = 32'h0; bus.op = 4'h0;
    bus.out_ready = 1'b1; bus.clr_sticky = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = 8'h0; bus8.b = 8'h0; bus8.op = 4'h0;
    bus8.out_ready = 1'b1; bus8.clr_sticky = 1'b0;
    #1;
    chk("reset_flags", {25'h0, bus.out_valid, bus.busy, bus.zero, bus.overflow, bus.set,
                        bus.cout, bus.sticky_ovf}, 32'h0);
    chk("reset_result", bus.result, 32'h0);
    chk("reset_in_ready", {31'h0, bus.in_ready}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'hFF0F_FFFF, 32'hFFFF_FFFF, 4'b0000, 32'hFF0F_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "and");
    issue(32'hFFFF_FFFF, 32'h0F00_00F0, 4'b0100, 32'hF0FF_FF0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "and_inv");
    issue(32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "or");
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0010, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "add_pos_ovf");
    issue(32'h8000_0000, 32'h8000_0000, 4'b0010, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "add_neg_ovf");
    issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0110, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "sub_eq");
    issue(32'h0000_0000, 32'hFFFF_FFFF, 4'b0111, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "slt_0_m1");
    issue(32'hFFFF_FFFF, 32'h0000_0000, 4'b0111, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "slt_m1_0");
    issue(32'h8000_0000, 32'h0000_0001, 4'b0111, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "slt_min_1");
    issue(32'h0000_0001, 32'h0000_0104, 4'b1001, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "sll_4");
    issue(32'h8000_0000, 32'h0000_001F, 4'b1010, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "srl_31");
    issue(32'h8000_0000, 32'h0000_0004, 4'b1011, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "sra_4");
    issue(32'h1234_5678, 32'h0000_0020, 4'b1001, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "sll_0");
    issue(32'hFFFF_FFFF, 32'h0000_0001, 4'b1100, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "reserved");

    // multiply with a second request queued behind it and the result back-pressured
    issue(32'h0001_0003, 32'h0000_0005, 4'b1000, 32'h0005_000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "mul");
    bus.out_ready = 1'b0;
    q.push_back('{res: 32'h3, z: 1'b0, o: 1'b0, s: 1'b0, c: 1'b0, zmask: 1'b0, nm: "add_queued"});
    bus.a = 32'h1; bus.b = 32'h2; bus.op = 4'b0010; bus.in_valid = 1'b1;
    bad = 1'b0;
    for (int k = 1; k < 32; k++) begin
      @(posedge clk); #1;
      if (!bus.busy || bus.in_ready || bus.out_valid) bad = 1'b1;
    end
    chk("mul_busy_window", {31'h0, bad}, 32'h0);
    @(posedge clk); #1;
    chk("mul_latency", {30'h0, bus.out_valid, bus.busy}, 32'h2);
    held = bus.result;
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus.result !== held || !bus.out_valid || bus.in_ready) bad = 1'b1;
    end
    chk("backpressure_hold", {31'h0, bad}, 32'h0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("b2b_result", bus.result, 32'h3);

    // 8-bit instance, SRA with back-pressure then drain
    q8.push_back('{res: 32'hF0, z: 1'b0, o: 1'b0, s: 1'b0, c: 1'b0, zmask: 1'b0, nm: "sra8"});
    bus8.a = 8'h80; bus8.b = 8'h03; bus8.op = 4'b1011; bus8.out_ready = 1'b0; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sra8_stall", {23'h0, bus8.out_valid, bus8.in_ready, bus8.result}, {23'h0, 1'b1, 1'b0, 8'hF0});
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;

    // reset in the middle of a multiply
    @(posedge clk); #1;
    issue(32'h0000_0003, 32'h0000_0005, 4'b1000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mul_abort");
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_async", {30'h0, bus.out_valid, bus.busy}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) bad = 1'b1;
    end
    chk("abort_no_result", {31'h0, bad}, 32'h0);

`ifdef ALU_STICKY_OVF_EN
    issue(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "add_ovf_st");
    chk("sticky_set", {31'h0, bus.sticky_ovf}, 32'h1);
    issue(32'h0000_0001, 32'h0000_0001, 4'b0010, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "add_1_1");
    chk("sticky_hold", {31'h0, bus.sticky_ovf}, 32'h1);
    bus.clr_sticky = 1'b1;
    @(posedge clk); #1;
    bus.clr_sticky = 1'b0;
    chk("sticky_clear", {31'h0, bus.sticky_ovf}, 32'h0);
    bus.clr_sticky = 1'b1;
    issue(32'h8000_0000, 32'h0000_0001, 4'b0110, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "sub_ovf_st");
    bus.clr_sticky = 1'b0;
    chk("sticky_set_priority", {31'h0, bus.sticky_ovf}, 32'h1);
`else
    issue(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "add_ovf_ns");
    chk("sticky_off", {31'h0, bus.sticky_ovf}, 32'h0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue32_empty", q.size(), 32'h0);
    chk("queue8_empty", q8.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
